// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA frame geometry, colours and target FSM encodings
package vga_pkg;

    localparam int FRAME_WIDTH  = 1280;
    localparam int FRAME_HEIGHT = 1024;

    localparam logic [11:0] COLOUR_BLACK = 12'h000;
    localparam logic [11:0] COLOUR_WHITE = 12'hFFF;
    localparam logic [11:0] COLOUR_RED   = 12'hF00;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SPAWN  = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_HIT    = 3'd3
    } state_t;

    // One subtraction is enough to bring any candidate below lim: cand < 2*lim always holds.
    function automatic logic [11:0] fold_pos(input logic [11:0] cand, input logic [11:0] lim);
        return (cand >= lim) ? (cand - lim) : cand;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - 16-bit Fibonacci LFSR, taps 16,14,13,11, free-running
module lfsr16 (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (reset) q <= seed;
        else       q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    end

endmodule

// File: rtl/target_scheduler.sv
// rtl/target_scheduler.sv - target spawn/hit/timeout game controller for the VGA overlay
module target_scheduler #(
    parameter int          FRAME_WIDTH     = vga_pkg::FRAME_WIDTH,
    parameter int          FRAME_HEIGHT    = vga_pkg::FRAME_HEIGHT,
    parameter int          MAX_SIZE        = 128,
    parameter int          MIN_SIZE        = 16,
    parameter int          SIZE_STEP       = 8,
    parameter int          HOLD_FRAMES     = 4,
    parameter int          TIMEOUT_FRAMES  = 600,
    parameter int          COOLDOWN_FRAMES = 30,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_start,
    input  logic        enable,
    input  logic        marker_valid,
    input  logic [11:0] MarkerCoord_X,
    input  logic [11:0] MarkerCoord_Y,
    output logic [11:0] Coord_X,
    output logic [11:0] Coord_Y,
    output logic [7:0]  targetSize,
    output logic        target_en,
    output logic        hit_pulse,
    output logic [15:0] score,
    output logic [7:0]  misses,
    output logic [2:0]  state_dbg
);

    import vga_pkg::*;

    localparam int HW = $clog2(HOLD_FRAMES) + 1;
    localparam int FW = $clog2(TIMEOUT_FRAMES) + 1;
    localparam int CW = $clog2(COOLDOWN_FRAMES) + 1;

    state_t         state, state_n;
    logic [11:0]    x_n, y_n;
    logic [7:0]     size_n;
    logic           en_n, hit_n;
    logic [15:0]    score_n;
    logic [7:0]     misses_n;
    logic [HW-1:0]  hold_cnt, hold_n;
    logic [FW-1:0]  frame_cnt, frame_n;
    logic [CW-1:0]  cool_cnt, cool_n;
    logic [15:0]    lfsr;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (LFSR_SEED),
        .q     (lfsr)
    );

    logic [11:0] spawn_x, spawn_y;
    always_comb begin
        spawn_x = fold_pos({1'b0, lfsr[10:0]}, 12'(FRAME_WIDTH)  - {4'd0, targetSize});
        spawn_y = fold_pos({2'b0, lfsr[15:6]}, 12'(FRAME_HEIGHT) - {4'd0, targetSize});
    end

    // Widened to 13 bits so coordinate + size never wraps.
    logic [12:0] mx, my, tx, ty, sz;
    logic        overlap, ov_valid;
    always_comb begin
        mx = {1'b0, MarkerCoord_X};
        my = {1'b0, MarkerCoord_Y};
        tx = {1'b0, Coord_X};
        ty = {1'b0, Coord_Y};
        sz = {5'd0, targetSize};
        overlap  = (mx < tx + sz) && (tx < mx + sz) && (my < ty + sz) && (ty < my + sz);
        ov_valid = overlap && marker_valid;
    end

    always_comb begin
        state_n  = state;
        x_n      = Coord_X;
        y_n      = Coord_Y;
        size_n   = targetSize;
        en_n     = target_en;
        hit_n    = 1'b0;
        score_n  = score;
        misses_n = misses;
        hold_n   = hold_cnt;
        frame_n  = frame_cnt;
        cool_n   = cool_cnt;
        if (frame_start) begin
            if (!enable) begin
                state_n = ST_IDLE;
                en_n    = 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state_n = ST_SPAWN;
                        size_n  = 8'(MAX_SIZE);
                        en_n    = 1'b0;
                    end
                    ST_SPAWN: begin
                        x_n     = spawn_x;
                        y_n     = spawn_y;
                        en_n    = 1'b1;
                        frame_n = '0;
                        hold_n  = '0;
                        state_n = ST_ACTIVE;
                    end
                    ST_ACTIVE: begin
                        hold_n = ov_valid ? hold_cnt + 1'b1 : '0;
                        // Hit is tested first so a hit on the timeout frame does not count a miss.
                        if (ov_valid && hold_cnt == HW'(HOLD_FRAMES - 1)) begin
                            hit_n   = 1'b1;
                            score_n = (score == 16'hFFFF) ? score : score + 16'd1;
                            size_n  = (targetSize >= 8'(MIN_SIZE + SIZE_STEP)) ?
                                      targetSize - 8'(SIZE_STEP) : 8'(MIN_SIZE);
                            en_n    = 1'b0;
                            cool_n  = '0;
                            hold_n  = '0;
                            state_n = ST_HIT;
                        end else if (frame_cnt == FW'(TIMEOUT_FRAMES - 1)) begin
                            misses_n = (misses == 8'hFF) ? misses : misses + 8'd1;
                            state_n  = ST_SPAWN;
                        end else begin
                            frame_n = frame_cnt + 1'b1;
                        end
                    end
                    ST_HIT: begin
                        cool_n = cool_cnt + 1'b1;
                        if (cool_cnt == CW'(COOLDOWN_FRAMES - 1)) state_n = ST_SPAWN;
                    end
                    default: state_n = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            Coord_X    <= '0;
            Coord_Y    <= '0;
            targetSize <= 8'(MAX_SIZE);
            target_en  <= 1'b0;
            hit_pulse  <= 1'b0;
            score      <= '0;
            misses     <= '0;
            hold_cnt   <= '0;
            frame_cnt  <= '0;
            cool_cnt   <= '0;
        end else begin
            state      <= state_n;
            Coord_X    <= x_n;
            Coord_Y    <= y_n;
            targetSize <= size_n;
            target_en  <= en_n;
            hit_pulse  <= hit_n;
            score      <= score_n;
            misses     <= misses_n;
            hold_cnt   <= hold_n;
            frame_cnt  <= frame_n;
            cool_cnt   <= cool_n;
        end
    end

    assign state_dbg = state;

endmodule
